// File: rtl/seq_pkg.sv
// Shared types and constants for the melody sequencer.
// Divider table is computed at elaboration from the clock frequency.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE
  } state_t;

  localparam int ENTRY_W = 13;
  localparam int CODE_W = 6;
  localparam int NOTE_CODE_MAX = 48;
  localparam logic [21:0] REST_DIV = 22'd1;
  localparam real SEMITONE = 1.0594630943592953;

  // code n -> MIDI 47+n; code 22 is A4 (440 Hz)
  function automatic logic [21:0] note_div(
    input int code,
    input int clk_hz
  );
    real f;
    int d;
    if (code == 0 || code > NOTE_CODE_MAX) return REST_DIV;
    f = 440.0;
    for (int i = 22; i < code; i++) f = f * SEMITONE;
    for (int i = code; i < 22; i++) f = f / SEMITONE;
    d = $rtoi(real'(clk_hz) / (2.0 * f) + 0.5) - 1;
    return d[21:0];
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody ROM: entry = {last, code_r[5:0], code_l[5:0]}.
// Unused addresses hold a silent entry marked last.
module melody_rom
  import seq_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    entry = {1'b1, 12'd0};
    case (int'(addr))
      0: entry = {1'b0, 6'd22, 6'd13};
      1: entry = {1'b0, 6'd24, 6'd15};
      2: entry = {1'b1, 6'd0, 6'd17};
      3: entry = {1'b0, 6'd25, 6'd20};
      4: entry = {1'b0, 6'd26, 6'd25};
      5: entry = {1'b0, 6'd0, 6'd49};
      6: entry = {1'b0, 6'd48, 6'd1};
      7: entry = {1'b1, 6'd37, 6'd30};
      default: ;
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Beat-stepped melody player feeding note_gen dividers.
// Define SEQ_LOOP_EN to restart from entry 0 instead of stopping at the end.
module melody_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [1:0]        tempo_sel,
  output logic [21:0]       note_div_left,
  output logic [21:0]       note_div_right,
  output logic [ADDR_W-1:0] beat_idx,
  output logic              playing
);

  localparam int CNT_W = $clog2(BEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] B = CNT_W'(BEAT_CYCLES);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] tempo_lim, cur_lim;
  logic [ENTRY_W-1:0] entry;
  logic last_beat, at_end;
  logic [21:0] div_tab [2**CODE_W];
  logic [21:0] left_d, right_d;

  melody_rom #(.ADDR_W(ADDR_W)) u_rom (
    .addr (beat_idx),
    .entry(entry)
  );

  for (genvar g = 0; g < 2**CODE_W; g++) begin : g_div
    localparam logic [21:0] DIV = note_div(g, CLK_HZ);
    assign div_tab[g] = DIV;
  end

  always_comb begin
    tempo_lim = B;
    unique case (tempo_sel)
      2'd0: tempo_lim = B;
      2'd1: tempo_lim = B - (B >> 2);
      2'd2: tempo_lim = B >> 1;
      2'd3: tempo_lim = B >> 2;
    endcase
  end

  // limit is sampled only at the first cycle of a beat
  assign cur_lim = (cnt_q == '0) ? tempo_lim : lim_q;
  assign last_beat = (cnt_q == cur_lim - 1'b1);
  assign at_end = entry[12] || (beat_idx == '1);

  always_comb begin
    state_d = state_q;
    idx_d = beat_idx;
    cnt_d = cnt_q;
    lim_d = lim_q;
    unique case (state_q)
      IDLE: begin
        if (!stop && play) begin
          state_d = PLAY;
          idx_d = '0;
          cnt_d = '0;
        end
      end
      PLAY: begin
        lim_d = cur_lim;
        if (stop) begin
          state_d = IDLE;
          idx_d = '0;
          cnt_d = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (last_beat) begin
          cnt_d = '0;
          if (at_end) begin
            idx_d = '0;
`ifdef SEQ_LOOP_EN
            state_d = PLAY;
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d = beat_idx + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          idx_d = '0;
          cnt_d = '0;
        end else if (play) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    left_d = REST_DIV;
    right_d = REST_DIV;
    if (state_q == PLAY) begin
      left_d = div_tab[entry[5:0]];
      right_d = div_tab[entry[11:6]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_idx <= '0;
      cnt_q <= '0;
      lim_q <= B;
      note_div_left <= REST_DIV;
      note_div_right <= REST_DIV;
    end else begin
      state_q <= state_d;
      beat_idx <= idx_d;
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      note_div_left <= left_d;
      note_div_right <= right_d;
    end
  end

  assign playing = (state_q == PLAY);

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: vector table, corner sequences and
// a randomized run against a beat-level reference model.
module tb_melody_sequencer;

  localparam int CLK_HZ = 100_000_000;
  localparam int BEAT = 16;
  localparam int AW = 3;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic play = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [21:0] note_div_left, note_div_right;
  logic [AW-1:0] beat_idx;
  logic playing;

  int compared = 0;
  int mismatched = 0;

  int rom_l [8] = '{13, 15, 17, 20, 25, 49, 1, 30};
  int rom_r [8] = '{22, 24, 0, 25, 26, 0, 48, 37};
  bit rom_last [8] = '{0, 0, 1, 0, 0, 0, 0, 1};

  melody_sequencer #(
    .CLK_HZ(CLK_HZ),
    .BEAT_CYCLES(BEAT),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .play(play),
    .pause(pause),
    .stop(stop),
    .tempo_sel(tempo_sel),
    .note_div_left(note_div_left),
    .note_div_right(note_div_right),
    .beat_idx(beat_idx),
    .playing(playing)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: no finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  function automatic int ref_div(input int code);
    real f;
    if (code == 0 || code > 48) return 1;
    f = 440.0 * (2.0 ** (real'(code - 22) / 12.0));
    return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5) - 1;
  endfunction

  function automatic int len_of(input int t);
    case (t)
      0: return BEAT;
      1: return BEAT - BEAT / 4;
      2: return BEAT / 2;
      default: return BEAT / 4;
    endcase
  endfunction

  function automatic logic [63:0] pack(
    input bit p, input int idx, input int l, input int r
  );
    return {16'd0, p, idx[2:0], l[21:0], r[21:0]};
  endfunction

  function automatic logic [63:0] dut_tuple();
    return {16'd0, playing, beat_idx, note_div_left, note_div_right};
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    play = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    tempo_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input bit p, input bit pa, input bit s);
    play = p;
    pause = pa;
    stop = s;
    @(negedge clk);
    play = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
  endtask

  task automatic measure(output int n, input int tempo_at);
    logic [AW-1:0] old;
    old = beat_idx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == tempo_at) tempo_sel = 2'd2;
    end while (beat_idx == old && n < 200);
  endtask

  typedef struct {
    bit p;
    bit pa;
    bit s;
    int wait_n;
    bit e_play;
    int e_idx;
    int e_l;
    int e_r;
    string name;
  } row_t;

  function automatic row_t mk(
    input bit p, input bit pa, input bit s, input int w,
    input bit ep, input int ei, input int el, input int er,
    input string nm
  );
    row_t r;
    r.p = p; r.pa = pa; r.s = s; r.wait_n = w;
    r.e_play = ep; r.e_idx = ei; r.e_l = el; r.e_r = er;
    r.name = nm;
    return r;
  endfunction

  // reference model state
  int m_mode, m_pos, m_el, m_len, m_l, m_r;

  task automatic model_step();
    int nl, nr;
    nl = (m_mode == 1) ? ref_div(rom_l[m_pos]) : 1;
    nr = (m_mode == 1) ? ref_div(rom_r[m_pos]) : 1;
    if (stop) begin
      m_mode = 0; m_pos = 0; m_el = 0;
    end else if (m_mode == 0) begin
      if (play) begin m_mode = 1; m_pos = 0; m_el = 0; end
    end else if (m_mode == 2) begin
      if (play) m_mode = 1;
    end else if (pause) begin
      m_mode = 2;
    end else begin
      if (m_el == 0) m_len = len_of(int'(tempo_sel));
      m_el++;
      if (m_el == m_len) begin
        m_el = 0;
        if (rom_last[m_pos] || m_pos == 7) begin
          m_pos = 0;
          if (!LOOP) m_mode = 0;
        end else begin
          m_pos++;
        end
      end
    end
    m_l = nl;
    m_r = nr;
  endtask

  initial begin
    row_t tbl[$];
    int c4, a4, e1l, e1r, e2l;
    int n;
    c4 = 191112;
    a4 = 113635;
    e1l = ref_div(15);
    e1r = ref_div(24);
    e2l = ref_div(17);

    tbl.push_back(mk(0, 0, 0, 49, 0, 0, 1, 1, "idle50"));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, "play_edge"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, c4, a4, "first_note"));
    tbl.push_back(mk(0, 0, 0, 13, 1, 0, c4, a4, "beat0_end"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, c4, a4, "idx1"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, e1l, e1r, "note1"));
    tbl.push_back(mk(0, 0, 0, 14, 1, 2, e1l, e1r, "idx2"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, e2l, 1, "note2"));
    tbl.push_back(mk(0, 0, 0, 14, LOOP, 0, e2l, 1, "melody_end"));
    if (LOOP) begin
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, c4, a4, "after_end"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, c4, a4, "stop_edge"));
    end else begin
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, "after_end"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, "stop_edge"));
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, "stop_silent"));

    @(negedge clk);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].p, tbl[i].pa, tbl[i].s);
      repeat (tbl[i].wait_n) @(negedge clk);
      check(tbl[i].name, dut_tuple(),
            pack(tbl[i].e_play, tbl[i].e_idx, tbl[i].e_l, tbl[i].e_r));
    end

    // tempo change mid-beat only affects the next beat
    do_reset();
    drive(1, 0, 0);
    measure(n, 0);
    check("beat0_len", 64'(n), 64'(16));
    measure(n, 5);
    check("beat1_len_keep", 64'(n), 64'(16));
    measure(n, 0);
    check("beat2_len_fast", 64'(n), 64'(8));
    check("end_playing", 64'(playing), 64'(LOOP));
    tempo_sel = 2'd0;

    // pause at beat_cnt=5, resume later
    do_reset();
    drive(1, 0, 0);
    repeat (5) @(negedge clk);
    drive(0, 1, 0);
    check("pause_edge", 64'({playing, beat_idx}), 64'(0));
    @(negedge clk);
    check("pause_silent", 64'({note_div_left, note_div_right}),
          64'({22'd1, 22'd1}));
    repeat (39) @(negedge clk);
    check("pause_hold", dut_tuple(), pack(0, 0, 1, 1));
    drive(1, 0, 0);
    check("resume_playing", 64'(playing), 64'(1));
    measure(n, 0);
    check("resume_len", 64'(n), 64'(11));

    // simultaneous stop/pause/play in PLAY
    do_reset();
    drive(1, 0, 0);
    measure(n, 0);
    repeat (3) @(negedge clk);
    check("pre_stop_idx", 64'(beat_idx), 64'(1));
    drive(1, 1, 1);
    check("all3_edge", 64'({playing, beat_idx}), 64'(0));
    @(negedge clk);
    check("all3_silent", dut_tuple(), pack(0, 0, 1, 1));

    // asynchronous reset mid-beat
    drive(1, 0, 0);
    repeat (20) @(negedge clk);
    check("pre_rst", dut_tuple(), pack(1, 1, e1l, e1r));
    #2 rst = 1'b1;
    #1 check("async_rst", dut_tuple(), pack(0, 0, 1, 1));
    @(negedge clk);
    rst = 1'b0;

    // randomized run against the reference model
    do_reset();
    m_mode = 0; m_pos = 0; m_el = 0; m_len = BEAT; m_l = 1; m_r = 1;
    for (int i = 0; i < 3000; i++) begin
      play = ($urandom_range(19) == 0);
      pause = ($urandom_range(39) == 0);
      stop = ($urandom_range(79) == 0);
      if ($urandom_range(29) == 0) tempo_sel = 2'($urandom_range(3));
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("random", dut_tuple(), pack(m_mode == 1, m_pos, m_l, m_r));
    end
    play = 1'b0;
    pause = 1'b0;
    stop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
